// File: rtl/nios2system_switch_debounce_if.sv
// Switch conditioning bundle between the raw pins and the switch PIO.
//   sw_raw     : raw switch pins, asynchronous to the consumer clock
//   sw_clean   : debounced, registered level (drives the PIO in_port)
//   sw_rise    : one-cycle pulse per bit when sw_clean goes 0->1
//   sw_fall    : one-cycle pulse per bit when sw_clean goes 1->0
//   sw_changed : one-cycle pulse when any bit rises or falls
// master drives the pins and observes the results; slave is the debouncer side.
interface nios2system_switch_debounce_if #(
  parameter int unsigned WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );
endinterface

// File: rtl/nios2system_switch_debounce.sv
// Per-bit synchroniser + stability-counter debouncer for the slide switches.
// Each bit is synchronised through SYNC_STAGES flops, then must differ from the
// current clean level for DEBOUNCE_CYCLES consecutive cycles before the clean
// level follows. Registered rise/fall/changed pulses mark the cycle in which the
// new clean level first becomes visible.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   sw_if  : slave side of the switch bundle (sw_raw in; sw_clean, sw_rise,
//            sw_fall, sw_changed out)
module nios2system_switch_debounce #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  nios2system_switch_debounce_if.slave        sw_if
);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must lie in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  clean_q, clean_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              changed_q, changed_d;
  logic [WIDTH-1:0]                  sync_last;

  // Stage 0 captures the pin; the highest index is the synchronised level.
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], sw_if.sw_raw};
  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync_last[i] == clean_q[i]) begin
        // Agreement at any point restarts qualification.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        clean_d[i] = sync_last[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync_last[i];
        fall_d[i]  = ~sync_last[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign sw_if.sw_clean   = clean_q;
  assign sw_if.sw_rise    = rise_q;
  assign sw_if.sw_fall    = fall_q;
  assign sw_if.sw_changed = changed_q;

endmodule

// File: tb/tb_nios2system_switch_debounce.sv
// Scoreboard bench: the driver pushes the hand-computed change event (cycle,
// clean level, rise, fall) for each directed stimulus; per-DUT monitors pop an
// entry whenever sw_changed pulses. dut1 uses DEBOUNCE_CYCLES=4, dut2 uses 1.
module tb_nios2system_switch_debounce;

  typedef struct {
    int         at;
    logic [9:0] clean;
    logic [9:0] rise;
    logic [9:0] fall;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  q1[$];
  ev_t  q2[$];
  logic [9:0] exp1 = '0;
  logic [9:0] exp2 = '0;

  nios2system_switch_debounce_if #(.WIDTH(10)) sw1 ();
  nios2system_switch_debounce_if #(.WIDTH(10)) sw2 ();

  nios2system_switch_debounce #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)
  ) dut1 (
    .clk(clk), .reset(reset), .sw_if(sw1.slave)
  );

  nios2system_switch_debounce #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(16)
  ) dut2 (
    .clk(clk), .reset(reset), .sw_if(sw2.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect1(input int at, input logic [9:0] nc);
    q1.push_back('{at: at, clean: nc, rise: nc & ~exp1, fall: exp1 & ~nc});
    exp1 = nc;
  endtask

  task automatic expect2(input int at, input logic [9:0] nc);
    q2.push_back('{at: at, clean: nc, rise: nc & ~exp2, fall: exp2 & ~nc});
    exp2 = nc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for dut1.
  initial forever begin
    @(posedge clk);
    #1;
    if (sw1.sw_changed === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected pulse: clean=%0h rise=%0h fall=%0h at cycle %0d",
                 sw1.sw_clean, sw1.sw_rise, sw1.sw_fall, cyc);
      end else begin
        ev_t e;
        e = q1.pop_front();
        chk("dut1 event cycle", cyc, e.at);
        chk("dut1 sw_clean", {22'd0, sw1.sw_clean}, {22'd0, e.clean});
        chk("dut1 sw_rise", {22'd0, sw1.sw_rise}, {22'd0, e.rise});
        chk("dut1 sw_fall", {22'd0, sw1.sw_fall}, {22'd0, e.fall});
      end
    end else if ((sw1.sw_rise | sw1.sw_fall) != 10'd0) begin
      total++; bad++;
      $display("FAIL dut1 pulse without sw_changed: rise=%0h fall=%0h", sw1.sw_rise, sw1.sw_fall);
    end
  end

  // Monitor for dut2.
  initial forever begin
    @(posedge clk);
    #1;
    if (sw2.sw_changed === 1'b1) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2 unexpected pulse: clean=%0h rise=%0h fall=%0h at cycle %0d",
                 sw2.sw_clean, sw2.sw_rise, sw2.sw_fall, cyc);
      end else begin
        ev_t e;
        e = q2.pop_front();
        chk("dut2 event cycle", cyc, e.at);
        chk("dut2 sw_clean", {22'd0, sw2.sw_clean}, {22'd0, e.clean});
        chk("dut2 sw_rise", {22'd0, sw2.sw_rise}, {22'd0, e.rise});
        chk("dut2 sw_fall", {22'd0, sw2.sw_fall}, {22'd0, e.fall});
      end
    end else if ((sw2.sw_rise | sw2.sw_fall) != 10'd0) begin
      total++; bad++;
      $display("FAIL dut2 pulse without sw_changed: rise=%0h fall=%0h", sw2.sw_rise, sw2.sw_fall);
    end
  end

  initial begin
    logic pat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int k;
    sw1.sw_raw = 10'h3FF;
    sw2.sw_raw = 10'h000;

    // Reset held with all switches on: outputs stay quiet.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset sw_clean", {22'd0, sw1.sw_clean}, 32'd0);
      chk("reset pulses", {11'd0, sw1.sw_rise, sw1.sw_fall, sw1.sw_changed}, 32'd0);
    end
    reset = 1'b0;
    k = cyc;
    expect1(k + 6, 10'h3FF);
    wait_cycles(10);

    // Drop bit 3, then a clean rising edge on bit 3.
    sw1.sw_raw = 10'h3F7;
    expect1(cyc + 6, 10'h3F7);
    wait_cycles(10);
    sw1.sw_raw = 10'h3FF;
    expect1(cyc + 6, 10'h3FF);
    wait_cycles(10);

    // Bounce rejection on bit 0: only the final run of four 1s qualifies.
    sw1.sw_raw = 10'h3FE;
    expect1(cyc + 6, 10'h3FE);
    wait_cycles(10);
    k = cyc;
    expect1(k + 11, 10'h3FF);
    for (int p = 0; p < 10; p++) begin
      sw1.sw_raw[0] = pat[p];
      @(negedge clk);
    end
    wait_cycles(6);

    // Simultaneous multi-bit change.
    sw1.sw_raw = 10'h001;
    expect1(cyc + 6, 10'h001);
    wait_cycles(10);
    sw1.sw_raw = 10'h200;
    expect1(cyc + 6, 10'h200);
    wait_cycles(10);

    // Pass-through instance: every toggle of bit 7 gets its own pulse.
    k = cyc;
    for (int j = 0; j < 8; j++) begin
      sw2.sw_raw = (j % 2 == 0) ? 10'h080 : 10'h000;
      expect2(k + j + 3, sw2.sw_raw);
      @(negedge clk);
    end
    wait_cycles(6);

    // Reset between edges while bit 5 is two counts into qualification.
    sw1.sw_raw = 10'h220;
    wait_cycles(4);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset sw_clean", {22'd0, sw1.sw_clean}, 32'd0);
    chk("midreset pulses", {11'd0, sw1.sw_rise, sw1.sw_fall, sw1.sw_changed}, 32'd0);
    exp1 = 10'h000;
    wait_cycles(2);
    chk("midreset held sw_clean", {22'd0, sw1.sw_clean}, 32'd0);
    reset = 1'b0;
    expect1(cyc + 6, 10'h220);
    wait_cycles(12);

    chk("dut1 missing events", q1.size(), 32'd0);
    chk("dut2 missing events", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
